alu_1bit: RTL and testbench



---
 rtl/alu_1bit.sv | 111 +++++++++++
 tb/tb_alu_1bit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_1bit.sv
// ---------------------------------------------------------------------------
// alu_1bit
//
// Purpose:
//   This is a single-bit ALU slice, the building block of the 32-bit MIPS ALU.
//   A wide ALU is built from N slices, with each slice's c_out wired to the
//   next slice's cin. Operand B can be inverted before use, so one slice
//   covers eight operations:
//     AND, OR, ADD, XOR, a&~b, a|~b, SUB and XNOR.
//   The result bit and the carry-out are both registered. An operation
//   applied at one rising edge shows up on the outputs right after that edge.
//
// Ports:
//   clk    in  1  rising-edge clock
//   rst    in  1  synchronous reset, active-high (clears res and c_out)
//   en     in  1  load enable: 1 = capture the new result, 0 = hold
//   a      in  1  operand A
//   b      in  1  operand B
//   cin    in  1  carry-in (used only by ADD/SUB; the LSB slice ties it
//                 to ctr[2] so that SUB forms a + ~b + 1)
//   ctr    in  3  operation select:
//                   ctr[2]   = invert B
//                   ctr[1:0] = function (AND/OR/ADD/XOR)
//   res    out 1  registered result bit
//   c_out  out 1  registered carry-out (always 0 for logic operations)
// ---------------------------------------------------------------------------
module alu_1bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] ctr,
  output logic       res,
  output logic       c_out
);

  // Function codes carried on ctr[1:0]. The B-inversion bit sits above these
  // and is orthogonal to them, so it is not part of the enum.
  typedef enum logic [1:0] {
    FN_AND = 2'b00,
    FN_OR  = 2'b01,
    FN_ADD = 2'b10,
    FN_XOR = 2'b11
  } fnSel_e;

  fnSel_e fnSel;

  logic bb;
  logic sum;
  logic carry;

  logic res_d;
  logic res_q;
  logic cOut_d;
  logic cOut_q;

  assign fnSel = fnSel_e'(ctr[1:0]);

  // Operand conditioning and the full adder.
  // B is optionally inverted first. With cin tied to 1 on the LSB slice,
  // the adder then computes the two's-complement subtraction a + ~b + 1.
  // The carry uses the majority form, so a slice's carry-out is a plain
  // function of its own three adder inputs.
  always_comb begin
    bb    = b ^ ctr[2];
    sum   = a ^ bb ^ cin;
    carry = (a & bb) | (a & cin) | (bb & cin);
  end

  // Function select and next-state for the output registers.
  // Only the ADD path may produce a carry. Logic operations force the
  // carry-out to 0, so that a chain of slices does not see a stale carry.
  // cin takes part only through sum/carry, so logic operations ignore it.
  // Priority at the edge is: reset, then load when en is high, else hold.
  always_comb begin
    res_d  = res_q;
    cOut_d = cOut_q;
    if (en) begin
      cOut_d = 1'b0;
      unique case (fnSel)
        FN_AND: res_d = a & bb;
        FN_OR:  res_d = a | bb;
        FN_ADD: begin
          res_d  = sum;
          cOut_d = carry;
        end
        FN_XOR: res_d = a ^ bb;
        default: res_d = 1'b0;
      endcase
    end
  end

  // Output registers with synchronous reset.
  // Reset wins over en. A result that was pending when rst is sampled high
  // is discarded, and the outputs read 0 from that edge onwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= 1'b0;
      cOut_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      cOut_q <= cOut_d;
    end
  end

  assign res   = res_q;
  assign c_out = cOut_q;

endmodule

// File: tb/tb_alu_1bit.sv
// ---------------------------------------------------------------------------
// tb_alu_1bit
//
// Purpose:
//   Self-checking bench for alu_1bit. A behavioural reference model computes
//   the expected outputs with plain integer arithmetic. The bench drives the
//   directed sequences first and then a block of random operations.
// ---------------------------------------------------------------------------
module tb_alu_1bit;

  logic       clk;
  logic       rst;
  logic       en;
  logic       a;
  logic       b;
  logic       cin;
  logic [2:0] ctr;
  logic       res;
  logic       c_out;

  int totalChecks;
  int badChecks;

  // Model state: the values the output registers should hold.
  // X until the first reset, matching the undefined power-up state.
  logic expRes;
  logic expCout;

  alu_1bit dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .ctr  (ctr),
    .res  (res),
    .c_out(c_out)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference behaviour, written from the operation table rather than
  // from gates:
  //   - Effective B is (1 - b) when ctr[2] is set.
  //   - ADD/SUB is an integer sum whose bit 1 is the carry.
  //   - Logic operations never carry.
  // Returns {carry, result}.
  function automatic logic [1:0] refModel(input logic ia, input logic ib,
                                          input logic ic, input logic [2:0] op);
    int opA;
    int opB;
    int total;
    int r;
    int c;
    opA = ia ? 1 : 0;
    opB = ib ? 1 : 0;
    if (op[2]) opB = 1 - opB;
    c = 0;
    case (op[1:0])
      2'd0: r = opA * opB;
      2'd1: r = (opA + opB > 0) ? 1 : 0;
      2'd2: begin
        total = opA + opB + (ic ? 1 : 0);
        r = total % 2;
        c = total / 2;
      end
      default: r = (opA + opB) % 2;
    endcase
    return {c[0], r[0]};
  endfunction

  // Compares an observed value with the expected value and reports any
  // mismatch. Every comparison made by the bench goes through this task.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Applies one cycle of inputs, then lets a rising edge pass.
  // The model register is updated with the same reset/enable priority the
  // design uses, and both outputs are checked #1 after the edge.
  task automatic applyStimulus(input string tag, input logic iRst, input logic iEn,
                               input logic ia, input logic ib, input logic ic,
                               input logic [2:0] op);
    logic [1:0] m;
    rst = iRst;
    en  = iEn;
    a   = ia;
    b   = ib;
    cin = ic;
    ctr = op;
    @(posedge clk);
    #1;
    if (iRst) begin
      expRes  = 1'b0;
      expCout = 1'b0;
    end else if (iEn) begin
      m = refModel(ia, ib, ic, op);
      expRes  = m[0];
      expCout = m[1];
    end
    checkOutput({tag, ".res"}, res, expRes);
    checkOutput({tag, ".c_out"}, c_out, expCout);
  endtask

  // Drives the directed test sequences, then the random block, and prints
  // the summary line.
  initial begin
    logic [2:0] opList [7];
    logic [1:0] ab;
    totalChecks = 0;
    badChecks   = 0;
    expRes  = 1'bx;
    expCout = 1'bx;
    rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0; ctr = 3'b000;
    @(posedge clk);
    #1;

    // Reset beats en with an ADD that would otherwise carry.
    applyStimulus("reset0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
    applyStimulus("reset1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
    checkOutput("resetConstRes", res, 1'b0);
    checkOutput("resetConstCout", c_out, 1'b0);
    applyStimulus("release", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
    checkOutput("releaseConstRes", res, 1'b1);
    checkOutput("releaseConstCout", c_out, 1'b1);

    // Sweep every operation code over all (a,b) pairs.
    // ADD is run with both cin values; SUB uses cin = 1.
    opList = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b101, 3'b111};
    foreach (opList[k]) begin
      for (int i = 0; i < 4; i++) begin
        ab = i[1:0];
        applyStimulus($sformatf("op%b_ab%b", opList[k], ab), 1'b0, 1'b1,
                      ab[1], ab[0], 1'b0, opList[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      applyStimulus($sformatf("add_cin1_ab%b", ab), 1'b0, 1'b1, ab[1], ab[0], 1'b1, 3'b010);
      applyStimulus($sformatf("sub_ab%b", ab), 1'b0, 1'b1, ab[1], ab[0], 1'b1, 3'b110);
    end

    // Logic operations ignore cin: cin = 1 must not change the result.
    applyStimulus("and_cin1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
    applyStimulus("xnor_cin1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111);

    // Hold: load 1+1, then keep en low while the inputs change.
    applyStimulus("holdLoad", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
      checkOutput($sformatf("holdConst%0d", i), res, 1'b0);
    end
    applyStimulus("holdRelease", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001);

    // Randomised operations, with occasional reset and disabled cycles.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($sformatf("rnd%0d", i),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
